// File: rtl/pla_vec_sequencer_if.sv
// Stream handshake bundle for pla_vec_sequencer: vector in, result out.
interface pla_vec_sequencer_if #(
   parameter int unsigned NX = 17,
   parameter int unsigned NZ = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [NX-1:0] in_x;
   logic          out_valid;
   logic          out_ready;
   logic [NX-1:0] out_x;
   logic [NZ-1:0] out_z;

   // Sequencer side: consumes vectors, produces results.
   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_x, out_z
   );

   // Environment side: produces vectors, consumes results.
   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_x, out_z
   );
endinterface

// File: rtl/pla_vec_sequencer.sv
// Registered stimulus/response wrapper around a combinational PLA.
// Stream mode applies one vector per handshake; sweep mode walks every
// input code and compacts the responses into a MISR signature.
module pla_vec_sequencer #(
   parameter int unsigned   NX     = 17,
   parameter int unsigned   NZ     = 16,
   parameter int unsigned   SETTLE = 1,
   parameter logic [NZ-1:0] POLY   = 16'h002D
) (
   input  logic                 clk,
   input  logic                 rst,
   pla_vec_sequencer_if.slave   bus,
   input  logic                 sweep_start,
   input  logic                 sig_clr,
   output logic [NX-1:0]        pla_x,
   input  logic [NZ-1:0]        pla_z,
   output logic [NZ-1:0]        signature,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      STREAM = 1'b0,
      SWEEP  = 1'b1
   } mode_t;

   localparam logic [3:0] SETTLE_W = 4'(SETTLE);

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [NX-1:0] pla_x_q, pla_x_d;
   logic [NX-1:0] out_x_q, out_x_d;
   logic [NZ-1:0] out_z_q, out_z_d;
   logic [NZ-1:0] sig_q, sig_d;
   logic [NX-1:0] count_q, count_d;
   logic [3:0]    wait_q, wait_d;

   logic          capture;
   logic          last_code;
   logic [NZ-1:0] sig_next;

   assign capture   = (state_q == DRIVE) && (wait_q == SETTLE_W);
   assign last_code = (count_q == '1);
   assign sig_next  = {sig_q[NZ-2:0], 1'b0} ^ (sig_q[NZ-1] ? POLY : '0) ^ pla_z;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sweep_start || bus.in_valid) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (capture) begin
               if (mode_q == STREAM) begin
                  state_d = EMIT;
               end else if (last_code) begin
                  state_d = DONE;
               end
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= STREAM;
         pla_x_q <= '0;
         out_x_q <= '0;
         out_z_q <= '0;
         sig_q   <= '0;
         count_q <= '0;
         wait_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         pla_x_q <= pla_x_d;
         out_x_q <= out_x_d;
         out_z_q <= out_z_d;
         sig_q   <= sig_d;
         count_q <= count_d;
         wait_q  <= wait_d;
      end
   end

   // Datapath next values: launch, settle count, capture and sweep step.
   always_comb begin
      mode_d  = mode_q;
      pla_x_d = pla_x_q;
      out_x_d = out_x_q;
      out_z_d = out_z_q;
      sig_d   = sig_q;
      count_d = count_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (sweep_start) begin
               mode_d  = SWEEP;
               count_d = '0;
               pla_x_d = '0;
               sig_d   = '0;
               wait_d  = '0;
            end else if (bus.in_valid) begin
               mode_d  = STREAM;
               pla_x_d = bus.in_x;
               wait_d  = '0;
            end else if (sig_clr) begin
               sig_d = '0;
            end
         end
         DRIVE: begin
            if (capture) begin
               sig_d = sig_next;
               if (mode_q == STREAM) begin
                  out_x_d = pla_x_q;
                  out_z_d = pla_z;
               end else if (!last_code) begin
                  count_d = count_q + NX'(1);
                  pla_x_d = count_q + NX'(1);
                  wait_d  = '0;
               end
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // State-decoded outputs and register drives.
   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !sweep_start;
      bus.out_valid = (state_q == EMIT);
      bus.out_x     = out_x_q;
      bus.out_z     = out_z_q;
      pla_x         = pla_x_q;
      signature     = sig_q;
      busy          = (state_q != IDLE);
      done          = (state_q == DONE);
   end

endmodule

// File: tb/tb_pla_vec_sequencer.sv
// Bench for pla_vec_sequencer: a 17-bit stream instance and a 2-bit
// sweep instance, each fed by a PLA model, checked by scoreboards.
module tb_pla_vec_sequencer;

   localparam int unsigned S_NX  = 17;
   localparam int unsigned S_SET = 1;
   localparam int unsigned W_NX  = 2;
   localparam int unsigned W_SET = 0;

   typedef struct {
      logic [16:0] x;
      logic [15:0] z;
      logic [15:0] sig;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- stream instance ----------------
   pla_vec_sequencer_if #(.NX(S_NX), .NZ(16)) s_if ();
   logic        s_sweep_start = 1'b0;
   logic        s_sig_clr     = 1'b0;
   logic [16:0] s_pla_x;
   logic [15:0] s_pla_z;
   logic [15:0] s_sig;
   logic        s_busy, s_done;
   logic        force_en  = 1'b0;
   logic [15:0] force_val = '0;
   logic        rand_ready  = 1'b0;
   logic        force_ready = 1'b1;
   logic        rnd_bit = 1'b1;
   logic [15:0] s_sig_model = '0;
   exp_t        s_sb[$];

   pla_vec_sequencer #(.NX(S_NX), .NZ(16), .SETTLE(S_SET), .POLY(16'h002D)) dut_s (
      .clk(clk), .rst(rst), .bus(s_if.slave),
      .sweep_start(s_sweep_start), .sig_clr(s_sig_clr),
      .pla_x(s_pla_x), .pla_z(s_pla_z),
      .signature(s_sig), .busy(s_busy), .done(s_done)
   );

   function automatic logic [15:0] pla_fn(input logic [16:0] x);
      return x[15:0] ^ {x[7:0], x[15:8]} ^ (x[16] ? 16'hA5C3 : 16'h0000);
   endfunction

   function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] z);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ z;
   endfunction

   assign s_pla_z      = force_en ? force_val : pla_fn(s_pla_x);
   assign s_if.out_ready = rand_ready ? rnd_bit : force_ready;
   always @(posedge clk) begin
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
   end

   // ---------------- sweep instance ----------------
   pla_vec_sequencer_if #(.NX(W_NX), .NZ(16)) w_if ();
   logic        w_sweep_start = 1'b0;
   logic        w_sig_clr     = 1'b0;
   logic [1:0]  w_pla_x;
   logic [15:0] w_pla_z;
   logic [15:0] w_sig;
   logic        w_busy, w_done;
   logic        w_prev_done = 1'b0;
   logic [15:0] w_sb[$];

   pla_vec_sequencer #(.NX(W_NX), .NZ(16), .SETTLE(W_SET), .POLY(16'h002D)) dut_w (
      .clk(clk), .rst(rst), .bus(w_if.slave),
      .sweep_start(w_sweep_start), .sig_clr(w_sig_clr),
      .pla_x(w_pla_x), .pla_z(w_pla_z),
      .signature(w_sig), .busy(w_busy), .done(w_done)
   );

   assign w_pla_z       = {14'b0, w_pla_x};
   assign w_if.out_ready = 1'b1;

   // Signature after folding the first n sweep responses (z = x).
   function automatic logic [15:0] sweep_sig(input int unsigned n);
      logic [15:0] s = '0;
      for (int unsigned i = 0; i < n; i++) s = misr(s, 16'(i));
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (s_if.out_valid) begin
            check("s_in_ready_in_emit", s_if.in_ready, 0);
            if (s_sb.size() == 0) begin
               check("s_unexpected_out_valid", 1, 0);
            end else begin
               check("s_out_x", s_if.out_x, s_sb[0].x);
               check("s_out_z", s_if.out_z, s_sb[0].z);
               check("s_out_sig", s_sig, s_sb[0].sig);
               if (s_if.out_ready) void'(s_sb.pop_front());
            end
         end
         check("s_no_done", s_done, 0);
         check("w_no_out_valid", w_if.out_valid, 0);
         if (w_done) begin
            check("w_done_width", w_prev_done, 0);
            if (w_sb.size() == 0) check("w_unexpected_done", 1, 0);
            else check("w_sweep_sig", w_sig, w_sb.pop_front());
         end
         w_prev_done = w_done;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [16:0] x, input logic fen, input logic [15:0] fval);
      int unsigned n = 0;
      @(posedge clk); #1;
      s_if.in_x = x;
      s_if.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_if.in_ready) break;
         n++;
         if (n > 300) begin
            check("send_timeout", 0, 1);
            s_if.in_valid = 1'b0;
            return;
         end
      end
      // DUT is idle here, so the previous capture is complete.
      force_en  = fen;
      force_val = fval;
      begin
         exp_t e;
         e.x = x;
         e.z = fen ? fval : pla_fn(x);
         s_sig_model = misr(s_sig_model, e.z);
         e.sig = s_sig_model;
         s_sb.push_back(e);
      end
      @(posedge clk); #1;
      s_if.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      forever begin
         @(negedge clk);
         if (s_sb.size() == 0 && s_if.in_ready) break;
         n++;
         if (n > 500) begin
            check("drain_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic clear_sig();
      wait_drain();
      @(posedge clk); #1 s_sig_clr = 1'b1;
      @(posedge clk); #1 s_sig_clr = 1'b0;
      s_sig_model = '0;
   endtask

   task automatic run_sweep(input logic prio);
      @(posedge clk); #1;
      w_sweep_start = 1'b1;
      if (prio) begin
         w_if.in_valid = 1'b1;
         w_if.in_x     = 2'b10;
         w_sig_clr     = 1'b1;
      end
      w_sb.push_back(sweep_sig(4));
      @(negedge clk);
      check("w_in_ready_at_start", w_if.in_ready, 0);
      @(posedge clk); #1;
      w_sweep_start = 1'b0;
      w_if.in_valid = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         @(negedge clk);
         check("w_pla_x_seq", w_pla_x, i);
         check("w_sig_seq", w_sig, sweep_sig(i));
         check("w_busy", w_busy, 1);
      end
      @(negedge clk);
      check("w_done_pulse", w_done, 1);
      check("w_final_sig", w_sig, sweep_sig(4));
      w_sig_clr = 1'b0;
      @(negedge clk);
      check("w_done_end", w_done, 0);
      check("w_busy_end", w_busy, 0);
      check("w_sig_hold", w_sig, sweep_sig(4));
      repeat (3) @(negedge clk);
      check("w_idle_after", w_busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      s_if.in_valid = 1'b0;
      s_if.in_x     = '0;
      w_if.in_valid = 1'b0;
      w_if.in_x     = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_s_busy", s_busy, 0);
      check("rst_s_pla_x", s_pla_x, 0);
      check("rst_s_sig", s_sig, 0);
      check("rst_s_out_valid", s_if.out_valid, 0);
      check("rst_s_out_x", s_if.out_x, 0);
      check("rst_s_out_z", s_if.out_z, 0);
      check("rst_w_done", w_done, 0);

      // Single stream vector with SETTLE=1 latency.
      send(17'h1ABCD, 1'b1, 16'h0001);
      @(negedge clk);
      check("single_pla_x", s_pla_x, 17'h1ABCD);
      check("single_valid_t", s_if.out_valid, 0);
      @(negedge clk);
      check("single_valid_t1", s_if.out_valid, 0);
      @(negedge clk);
      check("single_valid_t2", s_if.out_valid, 1);
      check("single_out_x", s_if.out_x, 17'h1ABCD);
      check("single_out_z", s_if.out_z, 16'h0001);
      check("single_sig", s_sig, 16'h0001);
      wait_drain();

      // Backpressure: result held while out_ready is low.
      force_ready = 1'b0;
      send(17'h0F0F0, 1'b1, 16'h1234);
      begin
         int unsigned n = 0;
         while (!s_if.out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("bp_valid_seen", s_if.out_valid, 1);
      end
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_valid", s_if.out_valid, 1);
      end
      @(posedge clk); #1 force_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_in_ready_after", s_if.in_ready, 1);
      check("bp_valid_dropped", s_if.out_valid, 0);

      // MISR feedback wrap.
      clear_sig();
      send(17'h00001, 1'b1, 16'h8000);
      wait_drain();
      check("misr_seed", s_sig, 16'h8000);
      send(17'h00002, 1'b1, 16'h0000);
      wait_drain();
      check("misr_wrap", s_sig, 16'h002D);
      clear_sig();
      send(17'h00003, 1'b1, 16'h0001);
      send(17'h00004, 1'b1, 16'h0000);
      wait_drain();
      check("misr_shift", s_sig, 16'h0002);

      // Randomized stream traffic with random backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k % 10 == 9) clear_sig();
         send(17'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom));
      end
      wait_drain();
      rand_ready = 1'b0;
      check("s_sig_final", s_sig, s_sig_model);

      // Reset aborting a long sweep.
      @(posedge clk); #1 s_sweep_start = 1'b1;
      @(posedge clk); #1 s_sweep_start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("abort_busy_before", s_busy, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", s_busy, 0);
      check("abort_done", s_done, 0);
      check("abort_pla_x", s_pla_x, 0);
      check("abort_sig", s_sig, 0);
      check("abort_out_valid", s_if.out_valid, 0);
      s_sig_model = '0;
      repeat (30) @(negedge clk);

      // Exhaustive sweep, then priority case with sig_clr held.
      run_sweep(1'b0);
      run_sweep(1'b1);
      check("w_sb_empty", w_sb.size(), 0);
      check("s_sb_empty", s_sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pla_vec_sequencer.md
Name: pla_vec_sequencer

Overview:
- Registered stimulus/response stage wrapped around a combinational espresso PLA block (e.g. the 17-in/16-out t2 array).
- Drives the PLA input bus from a register and samples the PLA output bus after a programmable settle time.
- Two operating paths:
  - stream: per-vector valid/ready in, per-result valid/ready out.
  - sweep: self-driven exhaustive input count with MISR signature compaction, for sign-off against the golden PLA table.

Parameters:
NX, 17, PLA input width (x bus)
NZ, 16, PLA output width (z bus), also MISR width
SETTLE, 1, extra wait cycles between driving pla_x and sampling pla_z (0..15)
POLY, 16'h002D, MISR feedback polynomial (low NZ bits used)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  stream vector valid
in_ready  out  1  stream vector accepted when in_valid&in_ready at clk edge
in_x  in  NX  stream input vector
sweep_start  in  1  one-cycle pulse: begin exhaustive sweep
sig_clr  in  1  clear signature (honoured in IDLE only)
pla_x  out  NX  registered drive to PLA inputs
pla_z  in  NZ  PLA outputs (combinational from pla_x)
out_valid  out  1  stream result valid
out_ready  in  1  downstream accepts result
out_x  out  NX  vector that produced out_z
out_z  out  NZ  captured PLA response
signature  out  NZ  MISR state
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- All flops update on rising clk; rst is synchronous and active-high.
- Reset values: state=IDLE; pla_x=0; out_x=0; out_z=0; signature=0; out_valid=0; done=0; count=0; wait counter=0.
- A reset mid-operation aborts immediately. No done pulse, no output handshake completes.
- States: IDLE, DRIVE, EMIT, DONE.
- in_ready = (state==IDLE) & ~sweep_start. This is combinational; sweep_start has priority over in_valid.
- IDLE:
  - sweep_start → count=0, pla_x=0, signature=0, mode=SWEEP, go DRIVE.
  - else if in_valid → pla_x=in_x, mode=STREAM, go DRIVE.
  - else if sig_clr → signature=0.
- DRIVE:
  - Wait counter runs SETTLE cycles; then capture on the next edge.
  - pla_x changes at edge k; pla_z is sampled at edge k+1+SETTLE.
- Capture edge actions:
  - signature := (signature<<1) ^ (signature[NZ-1] ? POLY : 0) ^ pla_z. This happens in both modes.
  - STREAM: out_x=pla_x, out_z=pla_z, out_valid=1, go EMIT.
  - SWEEP, count==2^NX-1: go DONE.
  - SWEEP, otherwise: count+1, pla_x=count+1, stay DRIVE with the wait counter reloaded.
- EMIT:
  - out_valid, out_x and out_z are held stable until out_valid&out_ready.
  - On the handshake edge: out_valid=0, go IDLE.
  - Stream cycle minimum: accept at t, out_valid from t+1+SETTLE, next accept no earlier than t+3+SETTLE (out_ready held high).
- DONE: done=1 for exactly one cycle, then IDLE. signature is held until the next sweep_start or sig_clr.
- Ignored inputs:
  - sweep_start and in_valid outside IDLE.
  - sig_clr outside IDLE.
- Wrap: count is NX bits with no wrap-past. The sweep terminates at all-ones. Total sweep length is 2^NX·(SETTLE+1) cycles after the start edge.
- pla_x holds its last value between operations.

Test Plan:
- Reset: assert rst with sweep running (NX=4). Required: next cycle busy=0, done=0, pla_x=0, signature=0, out_valid=0; no done pulse afterwards.
- Stream single (SETTLE=1, signature=0, model pla_z=16'h0001): in_x=17'h1ABCD accepted at edge t. Required:
  - pla_x=17'h1ABCD after t.
  - out_valid rises after t+2 with out_x=17'h1ABCD, out_z=16'h0001, signature=16'h0001.
- Backpressure: hold out_ready=0 for 5 cycles. Required:
  - out_valid/out_x/out_z stable and in_ready=0 throughout.
  - After the handshake, in_ready=1 the following cycle.
- MISR wrap (stream, seed signature to 16'h8000 via prior vectors, pla_z=0). Required: next signature=16'h002D. From signature=16'h0001 with pla_z=0: next signature=16'h0002.
- Sweep (NX=2, NZ=16, SETTLE=0, model pla_z=zero-extended pla_x), start at edge t0. Required:
  - pla_x sequence 0,1,2,3 on edges t0..t0+3.
  - Signature sequence after captures: 0,1,0,3.
  - done=1 for exactly one cycle after edge t0+4; final signature=16'h0003.
  - out_valid never asserted.
- Priority (IDLE): sweep_start=1 and in_valid=1 in the same cycle. Required: in_ready=0 that cycle, sweep runs, stream vector not consumed. sig_clr during the sweep has no effect.
